debounce_fsm: RTL and testbench

//  Cleans a raw mechanical switch/button input into a glitch-free level.

---
 rtl/debounce_fsm.sv | 53 +++++
 tb/tb_debounce_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronizes a raw bouncy switch and debounces it into a glitch-free level
//   CLK      in  system clock, all state updates on posedge
//   reset    in  asynchronous active-high reset
//   sw       in  raw asynchronous switch input
//   db_level out debounced level, decoded from state only
//   busy     out high while a candidate change is being timed
module debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic busy
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {ZERO = 2'b00, WAIT1 = 2'b01, ONE = 2'b10, WAIT0 = 2'b11} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sw_sync;
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], sw};
  assign sw_sync  = sync_q[SYNC_STAGES-1];
  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  assign busy     = (state_q == WAIT1) || (state_q == WAIT0);
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      sync_q  <= '0;
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      sync_q <= sync_d;
      case (state_q)
        ZERO:  if (sw_sync) begin
                 state_q <= WAIT1;
                 cnt_q   <= LOAD;
               end
        WAIT1: if (!sw_sync) state_q <= ZERO;
               else if (cnt_q == '0) state_q <= ONE;
               else cnt_q <= cnt_q - CW'(1);
        ONE:   if (!sw_sync) begin
                 state_q <= WAIT0;
                 cnt_q   <= LOAD;
               end
        WAIT0: if (sw_sync) state_q <= ONE;
               else if (cnt_q == '0) state_q <= ZERO;
               else cnt_q <= cnt_q - CW'(1);
        default: state_q <= ZERO;
      endcase
    end
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed stimulus with a run-length model and literal checkpoints
module tb_debounce_fsm;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic sw = 1'b0;
  logic db0, busy0, db1, busy1;
  int checks = 0;
  int errs = 0;
  int dcyc [2] = '{4, 1};
  int run [2] = '{0, 0};
  logic lvl [2] = '{1'b0, 1'b0};
  logic [1:0] hist = 2'b00;

  always #5 CLK = ~CLK;

  debounce_fsm #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut0 (
    .CLK(CLK), .reset(reset), .sw(sw), .db_level(db0), .busy(busy0));
  debounce_fsm #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) dut1 (
    .CLK(CLK), .reset(reset), .sw(sw), .db_level(db1), .busy(busy1));

  // Model: the level flips once the synchronized input has disagreed with it
  // for D+1 consecutive clock samples; busy means a disagreement run is open.
  always @(posedge CLK or posedge reset)
    if (reset) begin
      hist <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        run[i] <= 0;
        lvl[i] <= 1'b0;
      end
    end else begin
      hist <= {hist[0], sw};
      for (int i = 0; i < 2; i++)
        if (hist[1] != lvl[i]) begin
          if (run[i] + 1 == dcyc[i] + 1) begin
            lvl[i] <= hist[1];
            run[i] <= 0;
          end else run[i] <= run[i] + 1;
        end else run[i] <= 0;
    end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model db0", db0, lvl[0]);
    chk("model busy0", busy0, run[0] != 0);
    chk("model db1", db1, lvl[1]);
    chk("model busy1", busy1, run[1] != 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    // test 1: reset mid-cycle from a high level, then rise after release
    sw = 1'b1;
    tick(10);
    chk("t1 pre db", db0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t1 async db", db0, 1'b0);
    chk("t1 async busy", busy0, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(6);
    chk("t1 db edge5", db0, 1'b0);
    tick(1);
    chk("t1 db edge6", db0, 1'b1);
    // test 2: clean rising step timing
    sw = 1'b0;
    tick(10);
    chk("t2 idle db", db0, 1'b0);
    sw = 1'b1;
    tick(2);
    chk("t2 busy edge1", busy0, 1'b0);
    tick(1);
    chk("t2 busy edge2", busy0, 1'b1);
    tick(3);
    chk("t2 db edge5", db0, 1'b0);
    tick(1);
    chk("t2 db edge6", db0, 1'b1);
    chk("t2 busy edge6", busy0, 1'b0);
    // test 3: bounce aborts the first wait
    sw = 1'b0;
    tick(10);
    sw = 1'b1;
    tick(3);
    sw = 1'b0;
    tick(1);
    sw = 1'b1;
    tick(1);
    tick(1);
    chk("t3 abort busy", busy0, 1'b0);
    chk("t3 abort db", db0, 1'b0);
    tick(4);
    chk("t3 db early", db0, 1'b0);
    tick(1);
    chk("t3 db rise", db0, 1'b1);
    // test 4: short low dip from one never drops the level
    tick(3);
    sw = 1'b0;
    tick(3);
    sw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4 hold db", db0, 1'b1);
      tick(1);
    end
    sw = 1'b0;
    tick(6);
    chk("t4 db edge5", db0, 1'b1);
    tick(1);
    chk("t4 db fall", db0, 1'b0);
    // test 5: reset during wait1 discards the pending rise
    tick(3);
    sw = 1'b1;
    tick(4);
    chk("t5 busy pre", busy0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t5 async db", db0, 1'b0);
    chk("t5 async busy", busy0, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("t5 no stale rise", db0, 1'b0);
    tick(4);
    chk("t5 db edge5", db0, 1'b0);
    tick(1);
    chk("t5 db rise", db0, 1'b1);
    // test 6: single-cycle debounce instance
    sw = 1'b0;
    tick(10);
    chk("t6 idle db1", db1, 1'b0);
    sw = 1'b1;
    tick(3);
    chk("t6 db1 edge2", db1, 1'b0);
    chk("t6 busy1 edge2", busy1, 1'b1);
    tick(1);
    chk("t6 db1 edge3", db1, 1'b1);
    tick(4);
    sw = 1'b0;
    tick(1);
    sw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t6 pulse db1", db1, 1'b1);
      tick(1);
    end
    sw = 1'b0;
    tick(3);
    chk("t6 fall db1 edge2", db1, 1'b1);
    tick(1);
    chk("t6 fall db1 edge3", db1, 1'b0);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
